// File: rtl/cpu_pkg.sv
// Shared opcode, field-position and state-encoding constants for the control sequencer.
package cpu_pkg;

  localparam int NREG = 16;
  localparam int OPW  = 5;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01000;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01010;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01110;
  localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10000;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_T0     = 4'd1;
  localparam logic [3:0] S_T1     = 4'd2;
  localparam logic [3:0] S_T2     = 4'd3;
  localparam logic [3:0] S_T3     = 4'd4;
  localparam logic [3:0] S_T4     = 4'd5;
  localparam logic [3:0] S_T5     = 4'd6;
  localparam logic [3:0] S_T6     = 4'd7;
  localparam logic [3:0] S_T7     = 4'd8;
  localparam logic [3:0] S_HALTED = 4'd9;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_UNARY, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } op_class_t;

  function automatic op_class_t classify(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CLS_ALU;
      OP_NEG, OP_NOT:                 return CLS_UNARY;
      OP_MUL, OP_DIV:                 return CLS_MULDIV;
      OP_NOP:                         return CLS_NOP;
      OP_HALT:                        return CLS_HALT;
      default:                        return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_reg_select.sv
// Decodes a 4-bit register field into a one-hot register strobe, gated by enable.
module reg_select
  import cpu_pkg::*;
(
  input  logic [3:0]      field,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[field] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit: sequences fetch (T0-T3) and execute (T4-T7) for the single-bus datapath.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic            clock,
  input  logic            clear,
  input  logic            start,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic [NREG-1:0] rin,
  output logic [NREG-1:0] rout,
  output logic            pc_out,
  output logic            pc_in,
  output logic            inc_pc,
  output logic            mar_in,
  output logic            mdr_in,
  output logic            mdr_out,
  output logic            read,
  output logic            ir_in,
  output logic            y_in,
  output logic            z_in,
  output logic            zlow_out,
  output logic            zhigh_out,
  output logic            hi_in,
  output logic            lo_in,
  output logic [OPW-1:0]  alu_op,
  output logic            halted,
  output logic            illegal_op
);

  logic [3:0]      state, next_state;
  logic [OPW-1:0]  op;
  op_class_t       cls;
  logic            ra_in, ra_out, rb_out, rc_out;
  logic [NREG-1:0] oh_a, oh_b, oh_c;
  logic            ir_unused;

  assign op        = ir[OP_HI:OP_LO];
  assign cls       = classify(op);
  assign ir_unused = ^ir[RC_LO-1:0];

  reg_select u_sel_a (.field(ir[RA_HI:RA_LO]), .en(ra_in | ra_out), .onehot(oh_a));
  reg_select u_sel_b (.field(ir[RB_HI:RB_LO]), .en(rb_out),         .onehot(oh_b));
  reg_select u_sel_c (.field(ir[RC_HI:RC_LO]), .en(rc_out),         .onehot(oh_c));

  // Ra is the only write destination; any of the three fields may drive the bus.
  assign rin  = ra_in ? oh_a : '0;
  assign rout = (ra_out ? oh_a : '0) | oh_b | oh_c;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_T0;
      S_T0:     next_state = S_T1;
      S_T1:     next_state = S_T2;
      S_T2:     if (mem_ready) next_state = S_T3;
      S_T3:     next_state = S_T4;
      S_T4: begin
        case (cls)
          CLS_HALT:                       next_state = S_HALTED;
          CLS_ALU, CLS_UNARY, CLS_MULDIV: next_state = S_T5;
          default:                        next_state = S_T0;
        endcase
      end
      S_T5:     next_state = (cls == CLS_UNARY) ? S_T0 : S_T6;
      S_T6:     next_state = (cls == CLS_MULDIV) ? S_T7 : S_T0;
      S_T7:     next_state = S_T0;
      S_HALTED: next_state = S_HALTED;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0; mar_in = 1'b0;
    mdr_in = 1'b0; mdr_out = 1'b0; read = 1'b0; ir_in = 1'b0;
    y_in = 1'b0; z_in = 1'b0; zlow_out = 1'b0; zhigh_out = 1'b0;
    hi_in = 1'b0; lo_in = 1'b0; alu_op = '0; halted = 1'b0; illegal_op = 1'b0;
    ra_in = 1'b0; ra_out = 1'b0; rb_out = 1'b0; rc_out = 1'b0;
    case (state)
      S_T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
      S_T1: begin zlow_out = 1'b1; pc_in = 1'b1; end
      S_T2: begin read = 1'b1; mdr_in = 1'b1; end
      S_T3: begin mdr_out = 1'b1; ir_in = 1'b1; end
      S_T4: begin
        case (cls)
          CLS_ALU:     begin rb_out = 1'b1; y_in = 1'b1; end
          CLS_UNARY:   begin rb_out = 1'b1; z_in = 1'b1; alu_op = op; end
          CLS_MULDIV:  begin ra_out = 1'b1; y_in = 1'b1; end
          CLS_ILLEGAL: illegal_op = 1'b1;
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          CLS_ALU:    begin rc_out = 1'b1; z_in = 1'b1; alu_op = op; end
          CLS_UNARY:  begin zlow_out = 1'b1; ra_in = 1'b1; end
          CLS_MULDIV: begin rb_out = 1'b1; z_in = 1'b1; alu_op = op; end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          CLS_ALU:    begin zlow_out = 1'b1; ra_in = 1'b1; end
          CLS_MULDIV: begin zlow_out = 1'b1; lo_in = 1'b1; end
          default: ;
        endcase
      end
      S_T7:     begin zhigh_out = 1'b1; hi_in = 1'b1; end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer with hand sequences for reset/abort.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear, start, mem_ready;
  logic [31:0] ir;
  logic [15:0] rin, rout;
  logic        pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, ir_in;
  logic        y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
  logic [4:0]  alu_op;
  logic        halted, illegal_op;
  logic [52:0] obs;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [13:0] PC_OUT  = 14'h2000, PC_IN  = 14'h1000, INC_PC = 14'h0800;
  localparam logic [13:0] MAR_IN  = 14'h0400, MDR_IN = 14'h0200, MDR_OUT = 14'h0100;
  localparam logic [13:0] READ    = 14'h0080, IR_IN  = 14'h0040, Y_IN   = 14'h0020;
  localparam logic [13:0] Z_IN    = 14'h0010, ZLOW   = 14'h0008, ZHIGH  = 14'h0004;
  localparam logic [13:0] HI_IN   = 14'h0002, LO_IN  = 14'h0001;

  // ADD R4,R3,R7 / NOT R5,R0 / MUL R2,R6 / SUB R3,R3,R3 / DIV R0,R15
  localparam logic [31:0] I_ADD  = 32'h1A1B8000;
  localparam logic [31:0] I_NOT  = 32'h92800000;
  localparam logic [31:0] I_MUL  = 32'h71300000;
  localparam logic [31:0] I_SUB  = 32'h21998000;
  localparam logic [31:0] I_DIV  = 32'h78780000;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_BAD  = 32'hF8000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;

  typedef struct {
    logic        st;
    logic        mr;
    logic [31:0] i;
    logic [52:0] e;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  control_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .mem_ready(mem_ready),
    .rin(rin), .rout(rout), .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc),
    .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out), .read(read), .ir_in(ir_in),
    .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
    .hi_in(hi_in), .lo_in(lo_in), .alu_op(alu_op), .halted(halted),
    .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  assign obs = {rin, rout, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, ir_in,
                y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, alu_op, halted, illegal_op};

  function automatic logic [52:0] ex(input logic [15:0] ri, input logic [15:0] ro,
                                     input logic [13:0] st, input logic [4:0] op,
                                     input logic h, input logic il);
    return {ri, ro, st, op, h, il};
  endfunction

  task automatic check(input string nm, input logic [52:0] e);
    int bus;
    n_vec++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL %s: outputs %h, required %h", nm, obs, e);
    end
    bus = $countones({rout, pc_out, mdr_out, zlow_out, zhigh_out});
    n_vec++;
    if (bus > 1 || $countones(rin) > 1) begin
      n_bad++;
      $display("FAIL %s_onehot: bus drivers %0d rin %h, required <=1 each", nm, bus, rin);
    end
  endtask

  task automatic add(input logic st, input logic mr, input logic [31:0] i,
                     input logic [52:0] e, input string nm);
    vec_t v;
    v.st = st; v.mr = mr; v.i = i; v.e = e; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input logic [31:0] i, input int waits, input string nm);
    add(1'b1, 1'b1, i, ex(16'h0, 16'h0, PC_OUT | MAR_IN | INC_PC | Z_IN, 5'd0, 1'b0, 1'b0), {nm, "_t0"});
    add(1'b1, 1'b1, i, ex(16'h0, 16'h0, ZLOW | PC_IN, 5'd0, 1'b0, 1'b0), {nm, "_t1"});
    for (int w = 0; w < waits; w++)
      add(1'b0, 1'b0, i, ex(16'h0, 16'h0, READ | MDR_IN, 5'd0, 1'b0, 1'b0), {nm, "_t2wait"});
    add(1'b0, 1'b1, i, ex(16'h0, 16'h0, READ | MDR_IN, 5'd0, 1'b0, 1'b0), {nm, "_t2"});
    add(1'b0, 1'b0, i, ex(16'h0, 16'h0, MDR_OUT | IR_IN, 5'd0, 1'b0, 1'b0), {nm, "_t3"});
  endtask

  task automatic build_table();
    add(1'b0, 1'b0, 32'h0, '0, "idle0");
    add(1'b0, 1'b1, 32'h0, '0, "idle1");
    add(1'b1, 1'b0, I_ADD, '0, "idle_start");
    add_fetch(I_ADD, 3, "add");
    add(1'b0, 1'b1, I_ADD, ex(16'h0000, 16'h0008, Y_IN, 5'd0, 1'b0, 1'b0), "add_t4");
    add(1'b0, 1'b1, I_ADD, ex(16'h0000, 16'h0080, Z_IN, 5'b00011, 1'b0, 1'b0), "add_t5");
    add(1'b0, 1'b1, I_ADD, ex(16'h0010, 16'h0000, ZLOW, 5'd0, 1'b0, 1'b0), "add_t6");
    add_fetch(I_NOT, 0, "not");
    add(1'b0, 1'b1, I_NOT, ex(16'h0000, 16'h0001, Z_IN, 5'b10010, 1'b0, 1'b0), "not_t4");
    add(1'b0, 1'b1, I_NOT, ex(16'h0020, 16'h0000, ZLOW, 5'd0, 1'b0, 1'b0), "not_t5");
    add_fetch(I_MUL, 0, "mul");
    add(1'b0, 1'b1, I_MUL, ex(16'h0000, 16'h0004, Y_IN, 5'd0, 1'b0, 1'b0), "mul_t4");
    add(1'b0, 1'b1, I_MUL, ex(16'h0000, 16'h0040, Z_IN, 5'b01110, 1'b0, 1'b0), "mul_t5");
    add(1'b0, 1'b1, I_MUL, ex(16'h0000, 16'h0000, ZLOW | LO_IN, 5'd0, 1'b0, 1'b0), "mul_t6");
    add(1'b0, 1'b1, I_MUL, ex(16'h0000, 16'h0000, ZHIGH | HI_IN, 5'd0, 1'b0, 1'b0), "mul_t7");
    add_fetch(I_SUB, 1, "sub");
    add(1'b0, 1'b1, I_SUB, ex(16'h0000, 16'h0008, Y_IN, 5'd0, 1'b0, 1'b0), "sub_t4");
    add(1'b0, 1'b1, I_SUB, ex(16'h0000, 16'h0008, Z_IN, 5'b00100, 1'b0, 1'b0), "sub_t5");
    add(1'b0, 1'b1, I_SUB, ex(16'h0008, 16'h0000, ZLOW, 5'd0, 1'b0, 1'b0), "sub_t6");
    add_fetch(I_DIV, 0, "div");
    add(1'b0, 1'b1, I_DIV, ex(16'h0000, 16'h0001, Y_IN, 5'd0, 1'b0, 1'b0), "div_t4");
    add(1'b0, 1'b1, I_DIV, ex(16'h0000, 16'h8000, Z_IN, 5'b01111, 1'b0, 1'b0), "div_t5");
    add(1'b0, 1'b1, I_DIV, ex(16'h0000, 16'h0000, ZLOW | LO_IN, 5'd0, 1'b0, 1'b0), "div_t6");
    add(1'b0, 1'b1, I_DIV, ex(16'h0000, 16'h0000, ZHIGH | HI_IN, 5'd0, 1'b0, 1'b0), "div_t7");
    add_fetch(I_NOP, 0, "nop");
    add(1'b0, 1'b1, I_NOP, '0, "nop_t4");
    add_fetch(I_BAD, 0, "bad");
    add(1'b0, 1'b1, I_BAD, ex(16'h0, 16'h0, 14'h0, 5'd0, 1'b0, 1'b1), "bad_t4");
    add_fetch(I_HALT, 0, "halt");
    add(1'b0, 1'b1, I_HALT, '0, "halt_t4");
    for (int h = 0; h < 3; h++)
      add(1'b1, 1'b1, I_HALT, ex(16'h0, 16'h0, 14'h0, 5'd0, 1'b1, 1'b0), "halted");
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; mem_ready = 1'b0; ir = 32'h0;
    #2;
    check("reset", '0);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;

    build_table();
    for (int k = 0; k < vecs.size(); k++) begin
      start = vecs[k].st; mem_ready = vecs[k].mr; ir = vecs[k].i;
      @(negedge clock);
      check(vecs[k].nm, vecs[k].e);
      @(posedge clock); #1;
    end

    // Halted until cleared; clear acts immediately without a clock edge.
    start = 1'b0;
    #2;
    check("halt_hold", ex(16'h0, 16'h0, 14'h0, 5'd0, 1'b1, 1'b0));
    clear = 1'b0;
    #1;
    check("halt_clear", '0);
    #1 clear = 1'b1;
    @(posedge clock); #1;
    check("idle_after_clear", '0);

    start = 1'b1; mem_ready = 1'b1; ir = I_ADD;
    @(posedge clock); #1;
    start = 1'b0;
    check("resume_t0", ex(16'h0, 16'h0, PC_OUT | MAR_IN | INC_PC | Z_IN, 5'd0, 1'b0, 1'b0));
    repeat (5) @(posedge clock);
    #1;
    check("pre_abort_t5", ex(16'h0000, 16'h0080, Z_IN, 5'b00011, 1'b0, 1'b0));
    #2 clear = 1'b0;
    #1;
    check("abort_t5", '0);
    #1 clear = 1'b1;
    @(posedge clock); #1;
    check("abort_idle0", '0);
    repeat (2) @(posedge clock);
    #1;
    check("abort_idle2", '0);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("abort_resume_t0", ex(16'h0, 16'h0, PC_OUT | MAR_IN | INC_PC | Z_IN, 5'd0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
